// File: rtl/dm_ctrl.sv
// Round-robin two-port controller for a 1024x32 big-endian data memory; sub-word stores use read-modify-write.
// Optional define DM_CTRL_ALIGN_CHK_EN rejects misaligned half/word accesses with an error response.
module dm_ctrl #(
  parameter int   ADDR_W  = 10,
  parameter logic RR_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_sext,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic              b_sext,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MRG, S_WR, S_RESP} state_t;

  state_t            r_state;
  logic              r_last_gnt, r_owner, r_we, r_sext, r_err;
  logic [1:0]        r_size, r_lane;
  logic [ADDR_W-1:0] r_widx;
  logic [31:0]       r_wdata, r_rdata;

  logic        w_idle, w_gnt_a, w_gnt_b, w_we, w_sext, w_misalign;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_merge;
  logic        w_unused;

  // Both requesting: the port that did not win last time gets the grant.
  assign w_idle  = (r_state == S_IDLE) && !rst;
  assign w_gnt_a = w_idle && a_req && (!b_req || r_last_gnt);
  assign w_gnt_b = w_idle && b_req && (!a_req || !r_last_gnt);

  assign w_we     = w_gnt_b ? b_we    : a_we;
  assign w_size   = w_gnt_b ? b_size  : a_size;
  assign w_sext   = w_gnt_b ? b_sext  : a_sext;
  assign w_addr   = w_gnt_b ? b_addr  : a_addr;
  assign w_wdata  = w_gnt_b ? b_wdata : a_wdata;
  assign w_unused = ^w_addr[31:ADDR_W+2];

`ifdef DM_CTRL_ALIGN_CHK_EN
  assign w_misalign = (w_size == 2'b01) ? w_addr[0] : (w_size[1] && (w_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_byte  = 8'h00;
    w_merge = mem_rdata;
    unique case (r_lane)
      2'd0:    w_byte = mem_rdata[31:24];
      2'd1:    w_byte = mem_rdata[23:16];
      2'd2:    w_byte = mem_rdata[15:8];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    unique case (r_size)
      2'b00:   w_load = {{24{r_sext && w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sext && w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
    if (r_size == 2'b00) begin
      unique case (r_lane)
        2'd0:    w_merge[31:24] = r_wdata[7:0];
        2'd1:    w_merge[23:16] = r_wdata[7:0];
        2'd2:    w_merge[15:8]  = r_wdata[7:0];
        default: w_merge[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_size == 2'b01) begin
      if (r_lane[1]) w_merge[15:0]  = r_wdata[15:0];
      else           w_merge[31:16] = r_wdata[15:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_gnt <= RR_INIT;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_sext     <= 1'b0;
      r_lane     <= 2'b00;
      r_widx     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_gnt_a || w_gnt_b) begin
          r_last_gnt <= w_gnt_b;
          r_owner    <= w_gnt_b;
          r_we       <= w_we;
          r_size     <= w_size;
          r_sext     <= w_sext;
          r_lane     <= w_addr[1:0];
          r_widx     <= w_addr[ADDR_W+1:2];
          r_wdata    <= w_wdata;
          r_rdata    <= '0;
          r_err      <= w_misalign;
          if (w_misalign)               r_state <= S_RESP;
          else if (!w_we || !w_size[1]) r_state <= S_RD;
          else                          r_state <= S_WR;
        end
        S_RD:  r_state <= S_MRG;
        S_MRG: begin
          if (!r_we) r_rdata <= w_load;
          r_state <= S_RESP;
        end
        S_WR:    r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The write strobe is gated by rst so a reset landing in MRG kills the pending write.
  assign mem_addr  = r_widx;
  assign mem_re    = (r_state == S_RD);
  assign mem_we    = !rst && ((r_state == S_WR) || ((r_state == S_MRG) && r_we));
  assign mem_wdata = (r_state == S_WR) ? r_wdata :
                     ((r_state == S_MRG) && r_we) ? w_merge : 32'h0;

  assign a_gnt    = w_gnt_a;
  assign b_gnt    = w_gnt_b;
  assign a_rvalid = (r_state == S_RESP) && !r_owner;
  assign b_rvalid = (r_state == S_RESP) &&  r_owner;
  assign a_rdata  = a_rvalid ? r_rdata : 32'h0;
  assign b_rdata  = b_rvalid ? r_rdata : 32'h0;
  assign a_err    = a_rvalid && r_err;
  assign b_err    = b_rvalid && r_err;

endmodule
